mx_pc_unit: RTL and testbench

//   Program-counter source multiplexer for the datapath's fetch stage.
//   - Selects the next-PC value from one of two sources:
//     - the ALU result (branch/jump target);
//     - the PC adder output (sequential PC+4).
//   - Presents the selection combinationally on out.
//   - Also keeps a registered copy (pc_q) that feeds the instruction-memory address.

---
 rtl/mx_pc_unit.sv | 77 +++++++
 tb/tb_mx_pc_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mx_pc_unit.sv
// -----------------------------------------------------------------------------
// mx_pc_unit
//   Program-counter source multiplexer for the fetch stage.
//   Chooses the next PC from either the ALU result (branch/jump target) or the
//   PC adder output (sequential PC+4). The choice is presented combinationally
//   on `out`, and a registered copy `pc_q` drives the instruction-memory
//   address. `misaligned` flags a selected address that is not word aligned;
//   it is informational and never blocks a pc_q load.
//
// Ports
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset (pc_q only)
//   in_ALU      in   WIDTH  branch/jump target from the ALU
//   in_ADD      in   WIDTH  sequential next PC from the PC adder
//   S_MXPC      in   1      select: 0 -> in_ALU, 1 -> in_ADD
//   pc_we       in   1      pc_q load enable
//   out         out  WIDTH  combinational mux result
//   pc_q        out  WIDTH  registered PC
//   misaligned  out  1      combinational: out[1:0] != 2'b00
// -----------------------------------------------------------------------------
module mx_pc_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_ALU,
    input  logic [WIDTH-1:0] in_ADD,
    input  logic             S_MXPC,
    input  logic             pc_we,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] pc_q,
    output logic             misaligned
);

    // A PC is word aligned when its two byte-offset bits are zero.
    function automatic logic addr_misaligned(input logic [WIDTH-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    logic [WIDTH-1:0] mux_s;
    logic [WIDTH-1:0] pc_d;

    // Source select; deliberately independent of clk and rst_n so the
    // next-PC value is visible during reset and with the clock stopped.
    always_comb begin
        mux_s = in_ALU;
        if (S_MXPC == 1'b1) begin
            mux_s = in_ADD;
        end else begin
            mux_s = in_ALU;
        end
    end

    // Next-state value for the PC register: load the selection or hold.
    always_comb begin
        pc_d = pc_q;
        if (pc_we == 1'b1) begin
            pc_d = mux_s;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC register; reset forces the reset vector immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign out        = mux_s;
    assign misaligned = addr_misaligned(mux_s);

endmodule

// File: tb/tb_mx_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_mx_pc_unit
//   Self-checking bench for mx_pc_unit: directed scenarios for the
//   combinational path, asynchronous reset, load and hold, followed by
//   randomized stimulus compared against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_mx_pc_unit;

    localparam int          WIDTH = 32;
    localparam logic [31:0] RV    = 32'h0000_0000;

    logic        clk;
    logic        clk_en;
    logic        rst_n;
    logic [31:0] in_ALU;
    logic [31:0] in_ADD;
    logic        S_MXPC;
    logic        pc_we;
    logic [31:0] out;
    logic [31:0] pc_q;
    logic        misaligned;

    int n_checks;
    int n_pass;

    // Reference model state: the PC value the register should currently hold.
    logic [31:0] model_pc;

    mx_pc_unit #(
        .WIDTH        (WIDTH),
        .RESET_VECTOR (RV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_ALU     (in_ALU),
        .in_ADD     (in_ADD),
        .S_MXPC     (S_MXPC),
        .pc_we      (pc_we),
        .out        (out),
        .pc_q       (pc_q),
        .misaligned (misaligned)
    );

    // Gated clock so the combinational tests can run with no edges at all.
    always #5 begin
        if (clk_en) clk = ~clk;
    end

    // Single comparison point: counts and reports a mismatch.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Model of the mux: the chosen source, by name rather than by gate.
    function automatic logic [31:0] model_out(input logic sel, input logic [31:0] alu,
                                              input logic [31:0] add);
        if (sel) return add;
        return alu;
    endfunction

    function automatic logic [31:0] model_mis(input logic [31:0] addr);
        return ((addr % 32'd4) != 32'd0) ? 32'd1 : 32'd0;
    endfunction

    // Compare both combinational outputs against the model for current inputs.
    task automatic check_comb(input string tag);
        logic [31:0] e;
        e = model_out(S_MXPC, in_ALU, in_ADD);
        check({tag, "_out"}, out, e);
        check({tag, "_mis"}, {31'd0, misaligned}, model_mis(e));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        clk      = 1'b0;
        clk_en   = 1'b0;
        rst_n    = 1'b0;
        pc_we    = 1'b0;
        S_MXPC   = 1'b0;
        in_ALU   = 32'hFFFF_0000;
        in_ADD   = 32'h0000_FFFF;
        model_pc = RV;

        // 1: ALU selected, no clock.
        #1;
        check("t1_out", out, 32'hFFFF_0000);
        check("t1_mis", {31'd0, misaligned}, 32'd0);

        // 2: adder selected, no clock.
        S_MXPC = 1'b1;
        #1;
        check("t2_out", out, 32'h0000_FFFF);
        check("t2_mis", {31'd0, misaligned}, 32'd1);

        // 3: reset held, no clock: pc_q at reset vector, out still tracks select.
        check("t3_pc", pc_q, RV);
        S_MXPC = 1'b0;
        #1;
        check("t3_out", out, 32'hFFFF_0000);

        // 4: release reset, load ALU target on one edge.
        rst_n  = 1'b1;
        #1;
        clk_en = 1'b1;
        @(negedge clk);
        pc_we  = 1'b1;
        S_MXPC = 1'b0;
        in_ALU = 32'h0000_0040;
        @(posedge clk);
        #1;
        check("t4_pc", pc_q, 32'h0000_0040);

        // 5: load disabled for three edges: pc_q holds.
        @(negedge clk);
        pc_we  = 1'b0;
        in_ADD = 32'h0000_0044;
        S_MXPC = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t5_pc", pc_q, 32'h0000_0040);
        check("t5_out", out, 32'h0000_0044);

        // 6: reset pulse between edges, then reload from out.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_pc_rst", pc_q, RV);
        check("t6_out_rst", out, 32'h0000_0044);
        rst_n = 1'b1;
        pc_we = 1'b1;
        @(posedge clk);
        #1;
        check("t6_pc_reload", pc_q, 32'h0000_0044);
        model_pc = 32'h0000_0044;

        // Randomized run against the reference model.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            in_ALU = $urandom;
            in_ADD = $urandom;
            if ($urandom_range(0, 1) == 0) in_ALU[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 0) in_ADD[1:0] = 2'b00;
            S_MXPC = 1'($urandom_range(0, 1));
            pc_we  = 1'($urandom_range(0, 1));
            #1;
            check_comb("rnd");
            if ($urandom_range(0, 15) == 0) begin
                rst_n = 1'b0;
                #1;
                model_pc = RV;
                check("rnd_rst_pc", pc_q, model_pc);
                check_comb("rnd_rst");
                rst_n = 1'b1;
            end
            @(posedge clk);
            if (pc_we) model_pc = model_out(S_MXPC, in_ALU, in_ADD);
            #1;
            check("rnd_pc", pc_q, model_pc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
